simd_valu_pipe: RTL and testbench

Parametrised, elastic SIMD vector-ALU execution pipeline for the AES SIMD processor. It generalises the fixed scalar EX path to LANES independent lanes of LANE_W bits, a configurable depth of STAGES, valid/ready back-pressure, flush, and a pending-destination scoreboard that the hazard unit uses for vector register write-back hazards. It sits between vector decode/register read and vector write-back.

---
 rtl/simd_valu_pipe.sv | 105 ++++++++++
 tb/tb_simd_valu_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/simd_valu_pipe.sv
// Elastic SIMD vector-ALU pipeline: lane-wise XOR/ADD/AND/ROTB computed at entry, carried through
// STAGES registers with global stall, flush, and a pending-destination scoreboard for write-back hazards.
module simd_valu_pipe #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int STAGES = 3,
    parameter int REG_AW = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [LANES*LANE_W-1:0]    in_a,
    input  logic [LANES*LANE_W-1:0]    in_b,
    input  logic [REG_AW-1:0]          in_rd,
    input  logic                       in_wen,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*LANE_W-1:0]    out_result,
    output logic [REG_AW-1:0]          out_rd,
    output logic                       out_wen,
    output logic [(1<<REG_AW)-1:0]     pending
);
    localparam int DW       = LANES * LANE_W;
    localparam int NREG     = 1 << REG_AW;
    localparam int ROT_BITS = 8;

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] wen_r;
    logic [DW-1:0]     result_r [STAGES];
    logic [REG_AW-1:0] rd_r     [STAGES];
    logic              advance_s;
    logic              accept_s;
    logic [DW-1:0]     entry_result_s;

    // Adds are confined to one lane, so no carry can leak into the neighbour.
    function automatic logic [LANE_W-1:0] lane_op(input logic [1:0] op,
                                                  input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
        logic [LANE_W-1:0] r;
        case (op)
            2'b00:   r = a ^ b;
            2'b01:   r = a + b;
            2'b10:   r = a & b;
            2'b11:   r = (a << ROT_BITS) | (a >> (LANE_W - ROT_BITS));
            default: r = '0;
        endcase
        return r;
    endfunction

    assign advance_s  = !valid_r[STAGES-1] || out_ready;
    assign in_ready   = advance_s && !flush;
    assign accept_s   = in_valid && in_ready;
    assign out_valid  = valid_r[STAGES-1];
    assign out_result = result_r[STAGES-1];
    assign out_rd     = rd_r[STAGES-1];
    assign out_wen    = wen_r[STAGES-1];

    // Lane-wise ALU evaluated on the incoming operands.
    always_comb begin
        entry_result_s = '0;
        for (int l = 0; l < LANES; l++) begin
            entry_result_s[l*LANE_W +: LANE_W] = lane_op(in_op, in_a[l*LANE_W +: LANE_W],
                                                         in_b[l*LANE_W +: LANE_W]);
        end
    end

    // Stage registers: reset, then flush, then shift on advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            wen_r   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                result_r[i] <= '0;
                rd_r[i]     <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else if (advance_s) begin
            for (int i = STAGES-1; i > 0; i--) begin
                valid_r[i]  <= valid_r[i-1];
                wen_r[i]    <= wen_r[i-1];
                result_r[i] <= result_r[i-1];
                rd_r[i]     <= rd_r[i-1];
            end
            // Bubbles carry zero data so out_* stays clean until real work arrives.
            valid_r[0]  <= accept_s;
            wen_r[0]    <= accept_s && in_wen;
            result_r[0] <= accept_s ? entry_result_s : '0;
            rd_r[0]     <= accept_s ? in_rd : '0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Scoreboard: one-hot decode of every live writing stage, OR-ed together.
    always_comb begin
        pending = '0;
        for (int i = 0; i < STAGES; i++) begin
            pending = pending | ({{(NREG-1){1'b0}}, (valid_r[i] & wen_r[i])} << rd_r[i]);
        end
    end
endmodule

// File: tb/tb_simd_valu_pipe.sv
// Self-checking bench for simd_valu_pipe: directed vector table, hand-written stall/flush/scoreboard
// sequences and a randomized run against a slot-queue reference model.
module tb_simd_valu_pipe;
    localparam int L  = 4;
    localparam int W  = 32;
    localparam int S  = 3;
    localparam int A  = 5;
    localparam int DW = L * W;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, in_wen, flush, out_valid, out_ready, out_wen;
    logic [1:0]      in_op;
    logic [DW-1:0]   in_a, in_b, out_result;
    logic [A-1:0]    in_rd, out_rd;
    logic [(1<<A)-1:0] pending;

    simd_valu_pipe #(.LANES(L), .LANE_W(W), .STAGES(S), .REG_AW(A)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_wen(in_wen), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wen(out_wen), .pending(pending));

    always #5 clk = ~clk;

    typedef struct { bit v; logic [DW-1:0] r; logic [A-1:0] rd; bit wen; } slot_t;
    typedef struct { logic [DW-1:0] r; logic [A-1:0] rd; int cyc; } xfer_t;
    typedef struct { logic [1:0] op; logic [DW-1:0] a; logic [DW-1:0] b; logic [DW-1:0] exp; } vec_t;

    slot_t pipe_q[$];   // index 0 = newest stage, index S-1 = output stage
    xfer_t got_q[$];
    int    n_err = 0, n_checks = 0, cyc = 0;
    bit    last_accept;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic [31:0] x, y;
        longint s;
        r = '0;
        for (int l = 0; l < L; l++) begin
            x = a[l*W +: W];
            y = b[l*W +: W];
            s = (longint'(x) + longint'(y)) % 64'sd4294967296;
            case (op)
                2'b00:   r[l*W +: W] = x ^ y;
                2'b01:   r[l*W +: W] = s[31:0];
                2'b10:   r[l*W +: W] = x & y;
                default: r[l*W +: W] = {x[23:0], x[31:24]};
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (pipe_q[i]) if (pipe_q[i].v && pipe_q[i].wen) p[pipe_q[i].rd] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        slot_t e = '{1'b0, '0, '0, 1'b0};
        pipe_q.delete();
        repeat (S) pipe_q.push_back(e);
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic step();
        bit m_ovalid, m_ready;
        slot_t ns;
        #2;
        m_ovalid = pipe_q[S-1].v;
        m_ready  = (!m_ovalid || out_ready) && !flush;
        if (!rst) chk("in_ready", DW'(in_ready), DW'(m_ready));
        if (!rst && out_valid === 1'b1 && out_ready) got_q.push_back('{out_result, out_rd, cyc});
        @(posedge clk);
        cyc++;
        last_accept = 1'b0;
        if (rst) model_reset();
        else if (flush) foreach (pipe_q[i]) pipe_q[i].v = 1'b0;
        else if (!m_ovalid || out_ready) begin
            ns = '{in_valid, ref_alu(in_op, in_a, in_b), in_rd, in_wen};
            pipe_q.push_front(ns);
            void'(pipe_q.pop_back());
            last_accept = in_valid;
        end
        #1;
        chk("out_valid", DW'(out_valid), DW'(pipe_q[S-1].v));
        if (pipe_q[S-1].v) begin
            chk("out_result", out_result, pipe_q[S-1].r);
            chk("out_rd", DW'(out_rd), DW'(pipe_q[S-1].rd));
            chk("out_wen", DW'(out_wen), DW'(pipe_q[S-1].wen));
        end
        chk("pending", DW'(pending), DW'(model_pending()));
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [A-1:0] rd, input bit wen);
        in_valid = v; in_op = op; in_a = a; in_b = b; in_rd = rd; in_wen = wen;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{2'b01, 128'h00000003_00000002_00000001_FFFFFFFF,
                           128'h00000001_00000001_00000001_00000001,
                           128'h00000004_00000003_00000002_00000000};
        vecs[1] = '{2'b11, 128'h00000000_00000000_00000000_11223344,
                           128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF,
                           128'h00000000_00000000_00000000_22334411};
        vecs[2] = '{2'b00, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5,
                           128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5,
                           128'h00000000_00000000_00000000_00000000};
        vecs[3] = '{2'b10, 128'hF0F0F0F0_12345678_FFFFFFFF_00000000,
                           128'h0FF00FF0_FFFF0000_87654321_FFFFFFFF,
                           128'h00F000F0_12340000_87654321_00000000};
        vecs[4] = '{2'b11, 128'h80000001_01020304_FF000000_00000000,
                           128'h00000000_00000000_00000000_00000000,
                           128'h00000180_02030401_000000FF_00000000};
        vecs[5] = '{2'b01, 128'hFFFFFFFF_80000000_7FFFFFFF_00000010,
                           128'h00000002_80000000_00000001_00000020,
                           128'h00000001_00000000_80000000_00000030};

        model_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 2'b01, 128'h1234, 128'h1, 5'd3, 1'b1);

        // Reset held two cycles with a live input.
        repeat (2) begin
            step();
            chk("rst_out_valid", DW'(out_valid), '0);
            chk("rst_pending", DW'(pending), '0);
            chk("rst_out_result", out_result, '0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1 chk("rst_in_ready", DW'(in_ready), DW'(1'b1));

        // Directed vector table with latency checks.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), 1'b1);
            step();
            chk("vec_accept", DW'(last_accept), DW'(1'b1));
            in_valid = 1'b0;
            step();
            chk("vec_early", DW'(out_valid), DW'(1'b0));
            step();
            chk("vec_valid", DW'(out_valid), DW'(1'b1));
            chk("vec_result", out_result, vecs[i].exp);
            step();
        end

        // Back-pressure: five ops, stall once the first reaches the output.
        got_q.delete();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 2'b00, DW'(k), '0, 5'd1, 1'b0);
            step();
        end
        drive(1'b1, 2'b00, DW'(4), '0, 5'd1, 1'b0);
        out_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("bp_in_ready", DW'(in_ready), DW'(1'b0));
            chk("bp_hold", out_result, DW'(1));
            step();
        end
        out_ready = 1'b1;
        begin
            int k = 4;
            for (int c = 0; c < 12; c++) begin
                if (k <= 5) drive(1'b1, 2'b00, DW'(k), '0, 5'd1, 1'b0);
                else in_valid = 1'b0;
                step();
                if (last_accept) k++;
            end
        end
        chk("bp_count", DW'(got_q.size()), DW'(5));
        foreach (got_q[i]) begin
            chk("bp_order", got_q[i].r, DW'(i + 1));
            chk("bp_spacing", DW'(got_q[i].cyc - got_q[0].cyc), DW'(i));
        end

        // Flush with three writers in flight and a live input in the flush cycle.
        out_ready = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            drive(1'b1, 2'b00, DW'(k), '0, 5'(k), 1'b1);
            step();
        end
        chk("fl_pending", DW'(pending), DW'(32'h0000_001C));
        drive(1'b1, 2'b00, DW'(16'hBEEF), '0, 5'd9, 1'b1);
        flush = 1'b1;
        #1 chk("fl_in_ready", DW'(in_ready), DW'(1'b0));
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_out_valid", DW'(out_valid), DW'(1'b0));
        chk("fl_pending_clr", DW'(pending), '0);
        repeat (4) begin
            step();
            chk("fl_no_output", DW'(out_valid), DW'(1'b0));
        end

        // Scoreboard: writer to r5, then a non-writer to r7.
        got_q.delete();
        drive(1'b1, 2'b01, DW'(5), DW'(5), 5'd5, 1'b1);
        step();
        chk("sb_p5_set", DW'(pending[5]), DW'(1'b1));
        drive(1'b1, 2'b01, DW'(7), DW'(7), 5'd7, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step();
            in_valid = 1'b0;
            chk("sb_p7", DW'(pending[7]), DW'(1'b0));
            chk("sb_p5", DW'(pending[5]), DW'(got_q.size() == 0));
        end
        chk("sb_xfers", DW'(got_q.size()), DW'(2));

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom),
                  {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom},
                  5'($urandom), 1'($urandom));
            out_ready = $urandom_range(0, 9) < 7;
            flush     = $urandom_range(0, 39) == 0;
            rst       = $urandom_range(0, 99) == 0;
            step();
        end
        rst = 1'b0; flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
